// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus: instruction memory port, decoder handshake and execute feedback.
// master = fetch unit (drives request, instruction, pc and fault).
// slave  = surrounding pipeline/memory (drives ready, data and resolve info).
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] pc;
  logic        resolve_valid;
  logic [2:0]  Branch;
  logic        Zero;
  logic        Less;
  logic [31:0] imm;
  logic [31:0] rs1_data;
  logic        fault;

  modport master (
    output imem_req, imem_addr, instr, instr_valid, pc, fault,
    input  imem_ready, imem_rdata, instr_ready, resolve_valid,
           Branch, Zero, Less, imm, rs1_data
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_valid, pc, fault,
    output imem_ready, imem_rdata, instr_ready, resolve_valid,
           Branch, Zero, Less, imm, rs1_data
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Purpose: single-issue fetch FSM (FETCH -> ISSUE -> RESOLVE), computes next pc from branch info.
// Latency: 3 cycles minimum per instruction; first imem_req one cycle after reset release.
// Backpressure: waits indefinitely on imem_ready, instr_ready and resolve_valid; HALT on misaligned target.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  instr_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {FETCH, ISSUE, RESOLVE, HALT} state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic        r_instr_valid;
  logic        r_imem_req;
  logic        r_fault;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_pc_plus_imm;
  logic [31:0] w_jalr_tgt;
  logic [31:0] w_next_pc;
  logic        w_aligned;

  // All adds wrap modulo 2^32; jalr clears bit 0 before the alignment check.
  assign w_pc_plus4    = r_pc + 32'd4;
  assign w_pc_plus_imm = r_pc + bus.imm;
  assign w_jalr_tgt    = (bus.rs1_data + bus.imm) & ~32'h1;
  assign w_aligned     = (w_next_pc[1:0] == 2'b00);

  // Next-pc select from the branch type resolved by execute.
  always_comb begin
    w_next_pc = w_pc_plus4;
    case (bus.Branch)
      3'b001:  w_next_pc = w_pc_plus_imm;
      3'b010:  w_next_pc = w_jalr_tgt;
      3'b100:  w_next_pc = bus.Zero  ? w_pc_plus_imm : w_pc_plus4;
      3'b101:  w_next_pc = !bus.Zero ? w_pc_plus_imm : w_pc_plus4;
      3'b110:  w_next_pc = bus.Less  ? w_pc_plus_imm : w_pc_plus4;
      3'b111:  w_next_pc = !bus.Less ? w_pc_plus_imm : w_pc_plus4;
      default: w_next_pc = w_pc_plus4;
    endcase
  end

  // Fetch FSM with registered outputs; inputs not relevant to the current state are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= FETCH;
      r_pc          <= RESET_PC;
      r_instr       <= NOP;
      r_instr_valid <= 1'b0;
      r_imem_req    <= 1'b0;
      r_fault       <= 1'b0;
    end else begin
      case (r_state)
        FETCH: begin
          // The first cycle after reset only raises the request; memory data counts once requested.
          if (!r_imem_req) begin
            r_imem_req <= 1'b1;
          end else if (bus.imem_ready) begin
            r_instr       <= bus.imem_rdata;
            r_instr_valid <= 1'b1;
            r_imem_req    <= 1'b0;
            r_state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.instr_ready) begin
            r_instr_valid <= 1'b0;
            r_state       <= RESOLVE;
          end
        end
        RESOLVE: begin
          if (bus.resolve_valid) begin
            if (w_aligned) begin
              r_pc       <= w_next_pc;
              r_imem_req <= 1'b1;
              r_state    <= FETCH;
            end else begin
              r_fault <= 1'b1;
              r_state <= HALT;
            end
          end
        end
        default: begin
          r_imem_req    <= 1'b0;
          r_instr_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req    = r_imem_req;
  assign bus.imem_addr   = r_pc;
  assign bus.pc          = r_pc;
  assign bus.instr       = r_instr;
  assign bus.instr_valid = r_instr_valid;
  assign bus.fault       = r_fault;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: branch-selection vector table plus
// hand-written sequences for reset, stalls, coincident handshakes, HALT and mid-resolve reset.
module tb_instr_fetch_unit;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  instr_fetch_unit_if bus();

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] start_pc;
    logic [2:0]  br;
    logic        zero;
    logic        less;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] exp_pc;
    logic        exp_fault;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  task automatic check32(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h, expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic check1(input string nm, input int idx, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %b, expected %b", nm, idx, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.imem_ready    = 1'b0;
    bus.imem_rdata    = 32'h0;
    bus.instr_ready   = 1'b0;
    bus.resolve_valid = 1'b0;
    bus.Branch        = 3'b000;
    bus.Zero          = 1'b0;
    bus.Less          = 1'b0;
    bus.imm           = 32'h0;
    bus.rs1_data      = 32'h0;
  endtask

  // Leaves the bench at a falling edge with the DUT in FETCH and imem_req high.
  task automatic apply_reset();
    clear_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_fetch(input logic [31:0] w);
    check1("fetch_req", 0, bus.imem_req, 1'b1);
    bus.imem_ready = 1'b1;
    bus.imem_rdata = w;
    @(negedge clk);
    bus.imem_ready = 1'b0;
  endtask

  task automatic do_issue(input logic [31:0] w);
    check1("issue_valid", 0, bus.instr_valid, 1'b1);
    check32("issue_instr", 0, bus.instr, w);
    bus.instr_ready = 1'b1;
    @(negedge clk);
    bus.instr_ready = 1'b0;
  endtask

  task automatic do_resolve(input logic [2:0] br, input logic z, input logic l,
                            input logic [31:0] im, input logic [31:0] r1);
    bus.Branch = br; bus.Zero = z; bus.Less = l; bus.imm = im; bus.rs1_data = r1;
    bus.resolve_valid = 1'b1;
    @(negedge clk);
    bus.resolve_valid = 1'b0;
  endtask

  task automatic run_instr(input logic [31:0] w, input logic [2:0] br, input logic z,
                           input logic l, input logic [31:0] im, input logic [31:0] r1);
    do_fetch(w);
    do_issue(w);
    do_resolve(br, z, l, im, r1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;

    vecs[0]  = '{32'h10, 3'b100, 1'b1, 1'b0, 32'hFFFF_FFF8, 32'h0, 32'h08, 1'b0};
    vecs[1]  = '{32'h10, 3'b100, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'h0, 32'h14, 1'b0};
    vecs[2]  = '{32'h10, 3'b101, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'h0, 32'h08, 1'b0};
    vecs[3]  = '{32'h10, 3'b101, 1'b1, 1'b0, 32'hFFFF_FFF8, 32'h0, 32'h14, 1'b0};
    vecs[4]  = '{32'h20, 3'b110, 1'b0, 1'b1, 32'h40, 32'h0, 32'h60, 1'b0};
    vecs[5]  = '{32'h20, 3'b110, 1'b0, 1'b0, 32'h40, 32'h0, 32'h24, 1'b0};
    vecs[6]  = '{32'h20, 3'b111, 1'b0, 1'b0, 32'h40, 32'h0, 32'h60, 1'b0};
    vecs[7]  = '{32'h20, 3'b111, 1'b0, 1'b1, 32'h40, 32'h0, 32'h24, 1'b0};
    vecs[8]  = '{32'h100, 3'b001, 1'b0, 1'b0, 32'hFFFF_FF00, 32'h0, 32'h0, 1'b0};
    vecs[9]  = '{32'h100, 3'b010, 1'b0, 1'b0, 32'h2, 32'h2003, 32'h2004, 1'b0};
    vecs[10] = '{32'h100, 3'b011, 1'b1, 1'b1, 32'h40, 32'h0, 32'h104, 1'b0};
    vecs[11] = '{32'hFFFF_FFFC, 3'b000, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, 1'b0};
    vecs[12] = '{32'h100, 3'b010, 1'b0, 1'b0, 32'h4, 32'h1003, 32'h100, 1'b1};
    vecs[13] = '{32'h100, 3'b001, 1'b0, 1'b0, 32'h2, 32'h0, 32'h100, 1'b1};
    vecs[14] = '{32'h10, 3'b100, 1'b1, 1'b0, 32'hFFFF_FFF6, 32'h0, 32'h10, 1'b1};

    // Reset state, then first fetch with imem_ready already high.
    clear_inputs();
    rst_n = 1'b0;
    bus.imem_ready = 1'b1;
    bus.imem_rdata = 32'h0050_0093;
    #12;
    check32("rst_pc", 0, bus.pc, 32'h0);
    check32("rst_instr", 0, bus.instr, 32'h0000_0013);
    check1("rst_valid", 0, bus.instr_valid, 1'b0);
    check1("rst_fault", 0, bus.fault, 1'b0);
    check1("rst_req", 0, bus.imem_req, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check1("c1_req", 0, bus.imem_req, 1'b1);
    check32("c1_addr", 0, bus.imem_addr, 32'h0);
    check1("c1_valid", 0, bus.instr_valid, 1'b0);
    @(negedge clk);
    check1("c2_valid", 0, bus.instr_valid, 1'b1);
    check32("c2_instr", 0, bus.instr, 32'h0050_0093);
    check1("c2_req", 0, bus.imem_req, 1'b0);

    // Decoder stall for 5 cycles with stray memory data and resolve pulses.
    bus.imem_rdata    = 32'hDEAD_BEEF;
    bus.resolve_valid = 1'b1;
    bus.Branch        = 3'b001;
    bus.imm           = 32'h2;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check1("stall_valid", c, bus.instr_valid, 1'b1);
      check32("stall_instr", c, bus.instr, 32'h0050_0093);
      check1("stall_req", c, bus.imem_req, 1'b0);
      check1("stall_fault", c, bus.fault, 1'b0);
    end
    clear_inputs();
    do_issue(32'h0050_0093);
    do_resolve(3'b000, 1'b0, 1'b0, 32'h0, 32'h0);
    check32("seq_pc4", 0, bus.pc, 32'h4);

    // imem_ready and instr_ready together in FETCH: only the fetch completes.
    bus.imem_ready  = 1'b1;
    bus.instr_ready = 1'b1;
    bus.imem_rdata  = 32'h0010_0113;
    @(negedge clk);
    bus.imem_ready  = 1'b0;
    bus.instr_ready = 1'b0;
    check1("coin_valid", 0, bus.instr_valid, 1'b1);
    @(negedge clk);
    check1("coin_valid", 1, bus.instr_valid, 1'b1);
    check32("coin_instr", 0, bus.instr, 32'h0010_0113);
    do_issue(32'h0010_0113);
    do_resolve(3'b000, 1'b0, 1'b0, 32'h0, 32'h0);
    check32("seq_pc8", 0, bus.pc, 32'h8);

    // Misaligned jalr target halts until reset, whatever the inputs do.
    run_instr(32'h0040_8067, 3'b010, 1'b0, 1'b0, 32'h4, 32'h1003);
    bus.imem_ready    = 1'b1;
    bus.instr_ready   = 1'b1;
    bus.resolve_valid = 1'b1;
    bus.Branch        = 3'b000;
    for (int c = 0; c < 4; c++) begin
      check1("halt_fault", c, bus.fault, 1'b1);
      check1("halt_req", c, bus.imem_req, 1'b0);
      check1("halt_valid", c, bus.instr_valid, 1'b0);
      check32("halt_pc", c, bus.pc, 32'h8);
      @(negedge clk);
    end

    // Branch-selection table: reset, jal to the start pc, then the vector's instruction.
    for (int i = 0; i < NV; i++) begin
      apply_reset();
      if (vecs[i].start_pc != 32'h0)
        run_instr(32'h0000_006F, 3'b001, 1'b0, 1'b0, vecs[i].start_pc, 32'h0);
      run_instr(32'h0000_0063, vecs[i].br, vecs[i].zero, vecs[i].less, vecs[i].imm, vecs[i].rs1);
      check32("vec_pc", i, bus.pc, vecs[i].exp_pc);
      check32("vec_addr", i, bus.imem_addr, vecs[i].exp_pc);
      check1("vec_fault", i, bus.fault, vecs[i].exp_fault);
      check1("vec_req", i, bus.imem_req, !vecs[i].exp_fault);
    end

    // Asynchronous reset while RESOLVE sees resolve_valid.
    apply_reset();
    run_instr(32'h0000_006F, 3'b001, 1'b0, 1'b0, 32'h40, 32'h0);
    check32("mid_pc40", 0, bus.pc, 32'h40);
    do_fetch(32'h0000_0013);
    do_issue(32'h0000_0013);
    bus.Branch        = 3'b001;
    bus.imm           = 32'h20;
    bus.resolve_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check32("mid_pc", 0, bus.pc, 32'h0);
    check1("mid_valid", 0, bus.instr_valid, 1'b0);
    check1("mid_fault", 0, bus.fault, 1'b0);
    check1("mid_req", 0, bus.imem_req, 1'b0);
    check32("mid_instr", 0, bus.instr, 32'h0000_0013);
    @(negedge clk);
    check32("mid_pc", 1, bus.pc, 32'h0);
    clear_inputs();
    rst_n = 1'b1;
    @(negedge clk);
    check1("refetch_req", 0, bus.imem_req, 1'b1);
    check32("refetch_addr", 0, bus.imem_addr, 32'h0);
    run_instr(32'h0000_0013, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0);
    check32("refetch_pc", 0, bus.pc, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
